// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer: ping-pong 8x8 row-in/column-out transpose memory; optional sync flush port via DCT_TRANSPOSE_FLUSH_EN
module dct_transpose_buffer #(
    parameter int DATA_W = 15,
    parameter int N      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DCT_TRANSPOSE_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DATA_W-1:0] in_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*DATA_W-1:0] out_col,
    output logic [2:0]        out_col_idx,
    output logic              out_last
);
    logic [DATA_W-1:0] mem [2][N][N];
    logic [1:0] full;
    logic       wr_bank, rd_bank;
    logic [2:0] wr_row, rd_col;
    logic       flush_i, wr_fire, rd_fire;
`ifdef DCT_TRANSPOSE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif
    // rst_n gates in_ready so nothing is accepted while reset is held
    assign in_ready  = rst_n & ~full[wr_bank] & ~flush_i;
    assign out_valid = full[rd_bank] & ~flush_i;
    assign wr_fire   = in_valid & in_ready;
    assign rd_fire   = out_valid & out_ready;
    assign out_col_idx = out_valid ? rd_col : 3'd0;
    assign out_last    = out_valid & (rd_col == 3'd7);

    always_comb begin
        out_col = '0;
        for (int r = 0; r < N; r++)
            out_col[r*DATA_W +: DATA_W] = out_valid ? mem[rd_bank][r][rd_col] : '0;
    end

    always_ff @(posedge clk)
        if (wr_fire)
            for (int k = 0; k < N; k++)
                mem[wr_bank][wr_row][k] <= in_row[k*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= 3'd0;
            rd_col  <= 3'd0;
        end else if (flush_i) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= 3'd0;
            rd_col  <= 3'd0;
        end else begin
            if (wr_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end
            // full gating guarantees this never targets the bank being written
            if (rd_fire) begin
                rd_col <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// tb_dct_transpose_buffer: scoreboard bench for the ping-pong transpose buffer
module tb_dct_transpose_buffer;
    localparam int DW = 15;
    localparam int N  = 8;
    localparam int EW = N*DW + 4;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
    logic flush_s = 1'b0;
    logic [N*DW-1:0] in_row, out_col;
    logic [2:0] out_col_idx;

    int total = 0, bad = 0, cols = 0, part_n = 0;
    logic [N*DW-1:0] rows [N];
    logic [EW-1:0] exp_q [$];

    always #5 clk = ~clk;

    dct_transpose_buffer #(.DATA_W(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef DCT_TRANSPOSE_FLUSH_EN
        .flush(flush_s),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
        .out_col_idx(out_col_idx), .out_last(out_last)
    );

    // Scoreboard: pop on pending column handshake, push a transposed block when 8 rows are accepted
    always @(negedge clk) begin
        if (!rst_n || flush_s) begin
            part_n = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_col: got col=%h idx=%0d, required no column", out_col, out_col_idx);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    cols++;
                    if ({out_col, out_col_idx, out_last} !== e) begin
                        bad++;
                        $display("FAIL col: got col=%h idx=%0d last=%0b, required col=%h idx=%0d last=%0b",
                                 out_col, out_col_idx, out_last, e[EW-1:4], e[3:1], e[0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                rows[part_n] = in_row;
                part_n++;
                if (part_n == N) begin
                    for (int c = 0; c < N; c++) begin
                        logic [N*DW-1:0] col;
                        for (int r = 0; r < N; r++) col[r*DW +: DW] = rows[r][c*DW +: DW];
                        exp_q.push_back({col, 3'(c), c == N-1});
                    end
                    part_n = 0;
                end
            end
        end
    end

    function automatic logic [N*DW-1:0] mk_row(int base, int r);
        logic [N*DW-1:0] d;
        for (int c = 0; c < N; c++) d[c*DW +: DW] = DW'(base + r*8 + c);
        return d;
    endfunction

    task automatic send_row(input logic [N*DW-1:0] d);
        int i;
        in_valid = 1'b1;
        in_row = d;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i == 200) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=0 for 200 cycles, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int want_cols, input string name);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || cols != want_cols) begin
            bad++;
            $display("FAIL %s_drain: got out_valid=%b cols=%0d, required 0 and %0d", name, out_valid, cols, want_cols);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_col, out_col_idx, out_last} !== '0) begin
            bad++;
            $display("FAIL reset: got in_ready=%b out_valid=%b col=%h idx=%0d last=%b, required all 0",
                     in_ready, out_valid, out_col, out_col_idx, out_last);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [N*DW-1:0] c0;
        cols = 0;
        out_ready = 1'b1;
        for (int r = 0; r < N; r++) send_row(mk_row(0, r));
        for (int r = 0; r < N; r++) c0[r*DW +: DW] = DW'(r*8);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_col !== c0 || out_col_idx !== 3'd0) begin
            bad++;
            $display("FAIL single_latency: got valid=%b col=%h idx=%0d, required 1 %h 0", out_valid, out_col, out_col_idx, c0);
        end
        drain(8, "single");
    endtask

    task automatic test_streaming();
        cols = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_row = mk_row(100 + (i/8)*64, i%8);
            @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_ready row %0d: got in_ready=%b, required 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain(24, "stream");
    endtask

    task automatic test_back_to_back();
        cols = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_row = mk_row(300 + (i/8)*64, i%8);
            @(negedge clk);
            total++;
            if (in_ready !== (i < 16)) begin
                bad++;
                $display("FAIL bp_ready row %0d: got in_ready=%b, required %0b", i, in_ready, i < 16);
            end
            if (i < 16) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_drain col %0d: got out_valid=%b in_ready=%b, required 1 0", k, out_valid, in_ready);
            end
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_free: got in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 17; i < 24; i++) send_row(mk_row(300 + (i/8)*64, i%8));
        drain(24, "bp");
    endtask

    task automatic test_toggle();
        cols = 0;
        out_ready = 1'b0;
        for (int r = 0; r < N; r++) send_row(mk_row(600, r));
        for (int i = 0; i < 20; i++) begin
            out_ready = ~out_ready;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain(8, "toggle");
    endtask

    task automatic test_sign();
        logic [DW-1:0] pat [3];
        logic [N*DW-1:0] d;
        pat[0] = 15'h4001; pat[1] = 15'h7FFF; pat[2] = 15'h0000;
        cols = 0;
        out_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) d[c*DW +: DW] = pat[(r + c) % 3];
            send_row(d);
        end
        drain(8, "sign");
    endtask

    task automatic test_reset_mid();
        cols = 0;
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) send_row(mk_row(900, r));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_col !== '0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got out_valid=%b col=%h in_ready=%b, required 0 0 0", out_valid, out_col, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int r = 0; r < N; r++) send_row(mk_row(1200, r));
        drain(8, "reset_mid");
    endtask

`ifdef DCT_TRANSPOSE_FLUSH_EN
    task automatic test_flush();
        cols = 0;
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) send_row(mk_row(1500, r));
        flush_s = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush: got in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        flush_s = 1'b0;
        for (int r = 0; r < N; r++) send_row(mk_row(1800, r));
        drain(8, "flush");
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_row = '0;
        test_reset();
        test_single();
        test_streaming();
        test_back_to_back();
        test_toggle();
        test_sign();
        test_reset_mid();
`ifdef DCT_TRANSPOSE_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dct_transpose_buffer.md
Name: dct_transpose_buffer

Overview:
- Ping-pong 8x8 transpose memory between the row-pass 1D DCT and the column-pass 1D DCT of the 2D DCT pipeline.
- Accepts one 8-coefficient row per handshake from the row DCT and stores it in one of two banks.
- Once a bank holds 8 rows, it presents the block column by column to the column DCT.
- Two banks let one block fill while the previous one drains, giving one row in and one column out per cycle sustained.

Parameters:
- DATA_W, 15, coefficient width; sign-magnitude, bit DATA_W-1 is sign. Data is passed untouched.
- N, 8, rows/columns per block; fixed at 8, other values unsupported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_row valid
- in_ready  out  1  buffer can accept a row
- in_row  in  N*DATA_W  row coefficients; lane k = bits [k*DATA_W +: DATA_W] = column k
- out_valid  out  1  out_col valid
- out_ready  in  1  downstream accepts column
- out_col  out  N*DATA_W  column coefficients; lane r = row r of current column
- out_col_idx  out  3  index of column on out_col
- out_last  out  1  high with column 7 of a block

Behaviour:
- State per bank b (0/1): full[b], plus 8x8xDATA_W storage. Pointers: wr_bank, wr_row[2:0], rd_bank, rd_col[2:0].
- Reset (async, rst_n=0):
  - full = 0, all pointers = 0, in_ready = 0 while reset is asserted.
  - out_valid = 0, out_col = 0, out_col_idx = 0, out_last = 0.
  - Storage contents are not reset.
- Write side:
  - in_ready = !full[wr_bank] (registered flags only, no combinational path from out_ready).
  - On in_valid & in_ready: store lane k into bank[wr_bank][wr_row][k], then increment wr_row.
  - When wr_row=7 is written: set full[wr_bank], toggle wr_bank, wr_row wraps to 0.
  - in_valid with in_ready low has no effect. The upstream must hold data; not checked.
- Read side:
  - out_valid = full[rd_bank].
  - out_col lane r = bank[rd_bank][r][rd_col]; out_col_idx = rd_col; out_last = (rd_col==7).
  - When out_valid is low: out_col, out_col_idx and out_last are forced to 0.
  - On out_valid & out_ready: increment rd_col. When rd_col=7 is consumed: clear full[rd_bank], toggle rd_bank, rd_col wraps to 0.
- Latency: 8th row accepted at edge t, so out_valid is high in the cycle after edge t; column 0 is readable then.
- Freed bank: becomes writable the cycle after its last column handshake.
- Throughput: continuous 1 row/cycle in with out_ready=1 never drops in_ready.
- Simultaneous events:
  - Last-row write and last-column read on different banks in the same cycle: both update independently.
  - A bank cannot be written and read in the same cycle, because its full flag gates both.
- Both banks full: in_ready=0 until a drain completes.
- out_ready may toggle freely. Columns are never skipped or duplicated.
- Reset mid-block: partial block discarded; first row after reset is row 0 of bank 0.

Optional Feature:
- Macro: DCT_TRANSPOSE_FLUSH_EN.
- When defined, adds port flush (in, 1), synchronous. On a cycle with flush=1:
  - Clear both full flags and all pointers.
  - Ignore in_valid; in_ready=0 and out_valid=0 that cycle.
  - Resume at row 0 of bank 0 the next cycle.
- When not defined: no flush port and no flush logic; behaviour is identical to the flush-never-asserted case.

Test Plan:
- Single block, in_row r lane c = r*8+c, out_ready=1:
  - Column 0 appears the cycle after the 8th row, lanes = 0,8,16,...,56, out_col_idx=0.
  - Column 7 lanes = 7,15,...,63 with out_last=1.
  - out_valid drops after 8 columns.
- Streaming: 24 rows on consecutive cycles, out_ready=1 -> in_ready stays 1 throughout; 24 columns out in 3 correctly transposed blocks, out_last every 8th.
- Back-pressure: out_ready=0, 17 rows offered -> first 16 accepted, in_ready=0 at the 17th. Raise out_ready -> after 8 column handshakes in_ready=1 on the next cycle and row 17 is accepted.
- Toggling out_ready (1,0,1,0...) on one block -> columns 0..7 each delivered exactly once, in order, values intact.
- Sign-magnitude pass-through: lane values 15'h4001, 15'h7FFF, 15'h0000 -> appear bit-identical in the transposed position.
- Reset mid-block: 5 rows written, rst_n low 2 cycles -> out_valid=0, out_col=0. Then 8 new rows -> output is only the new block.
- With DCT_TRANSPOSE_FLUSH_EN: 3 rows, flush one cycle, then 8 rows -> only the 8-row block is output.
